spw_axil_cfg_sequencer: RTL

AXI4-Lite master that brings up the SpaceWire_light AXI register slave without processor involvement. On a start pulse it writes NUM_CFG (address, data) pairs to the core's register file, then polls a status register until the link-run bits are set, or until a timeout. It sits between system-level bring-up logic and the S00_AXI port of the SpaceWire_light AXI core, in place of the PS master.

---
 rtl/spw_axil_cfg_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spw_axil_cfg_sequencer.sv
// AXI4-Lite bring-up master for the SpaceWire_light register slave: writes a table of
// (address, data) pairs, then polls a status register until the run bits are set or time runs out.
module spw_axil_cfg_sequencer #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           NUM_CFG        = 4,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR    = 32'h0000_000C,
  parameter logic [DATA_WIDTH-1:0] RUN_MASK       = 32'h0000_0001,
  parameter int unsigned           POLL_GAP       = 16,
  parameter int unsigned           TIMEOUT_CYCLES = 100000
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  input  logic [NUM_CFG*ADDR_WIDTH-1:0] cfg_addr,
  input  logic [NUM_CFG*DATA_WIDTH-1:0] cfg_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [DATA_WIDTH-1:0]         status_q,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [2:0]                    m_awprot,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [2:0]                    m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam int unsigned   IW   = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CFG - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, GAP, DONE, ERR} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           load_idx;
  logic [ADDR_WIDTH-1:0]   load_addr;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    aw_ok, w_ok;
  logic                    aw_hs, w_hs;
  logic [31:0]             timer, gap_cnt;
  logic                    expired, hit, pass, b_err, r_err;

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;
  assign m_wstrb  = '1;
  assign m_araddr = STATUS_ADDR;

  always_comb begin
    aw_hs     = m_awvalid && m_awready;
    w_hs      = m_wvalid && m_wready;
    load_idx  = (state == WR_RESP) ? idx + 1'b1 : '0;
    load_addr = cfg_addr[ADDR_WIDTH*int'(load_idx) +: ADDR_WIDTH];
    load_data = cfg_data[DATA_WIDTH*int'(load_idx) +: DATA_WIDTH];
    // hit marks the TIMEOUT_CYCLES-th cycle spent polling
    hit       = !expired && (timer == 32'(TIMEOUT_CYCLES - 1));
    pass      = (m_rdata & RUN_MASK) == RUN_MASK;
    b_err     = m_bresp inside {2'b10, 2'b11};
    r_err     = m_rresp inside {2'b10, 2'b11};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      idx       <= '0;
      aw_ok     <= 1'b0;
      w_ok      <= 1'b0;
      timer     <= '0;
      gap_cnt   <= '0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      status_q  <= '0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      if (aw_hs) m_awvalid <= 1'b0;
      if (w_hs) m_wvalid <= 1'b0;
      if (m_arvalid && m_arready) m_arvalid <= 1'b0;
      if ((state inside {RD_REQ, RD_RESP, GAP}) && !expired) timer <= timer + 32'd1;

      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= WR_REQ;
            idx       <= '0;
            m_awaddr  <= load_addr;
            m_wdata   <= load_data;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_ok <= 1'b1;
          if (w_hs) w_ok <= 1'b1;
          if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
            state    <= WR_RESP;
            m_bready <= 1'b1;
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            if (b_err) begin
              state    <= ERR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd1;
            end else if (idx == LAST) begin
              state     <= RD_REQ;
              m_arvalid <= 1'b1;
              timer     <= '0;
              expired   <= 1'b0;
            end else begin
              state     <= WR_REQ;
              idx       <= load_idx;
              m_awaddr  <= load_addr;
              m_wdata   <= load_data;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          // an issued AR is always carried through to its R beat, even after expiry
          if (hit) expired <= 1'b1;
          if (m_arready) begin
            state    <= RD_RESP;
            m_rready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            status_q <= m_rdata;
            if (r_err) begin
              state    <= ERR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd3;
            end else if (pass && !expired) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (expired || hit) begin
              state    <= ERR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd2;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end else if (hit) begin
            expired <= 1'b1;
          end
        end
        GAP: begin
          if (hit) begin
            state    <= ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd2;
          end else if (gap_cnt == 32'(POLL_GAP - 1)) begin
            state     <= RD_REQ;
            m_arvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
